// File: rtl/ofmd_wr_addr_gener.sv
// OFMD write-side address generator: accumulates KxK tap products per window and writes each
// output pixel in raster order. Optional build macro OFMD_RELU_EN clamps written sums at zero.
module ofmd_wr_addr_gener #(
  parameter int unsigned IFMD_H = 8,
  parameter int unsigned IFMD_W = 8,
  parameter int unsigned KW_3   = 3,
  parameter int unsigned KW_5   = 5,
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 21,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_5x5,
  input  logic                     prod_valid,
  input  logic signed [PROD_W-1:0] prod_data,
  input  logic                     win_last,
  output logic                     ofmd_wr_en,
  output logic [ADDR_W-1:0]        ofmd_wr_addr,
  output logic signed [ACC_W-1:0]  ofmd_wr_data,
  output logic                     ofmd_wr_done,
  output logic                     busy,
  output logic                     align_err
);

  localparam int unsigned TapW = $clog2(KW_5 * KW_5);
  localparam logic [TapW-1:0] LastTap3 = TapW'(KW_3 * KW_3 - 1);
  localparam logic [TapW-1:0] LastTap5 = TapW'(KW_5 * KW_5 - 1);
  localparam logic [ADDR_W-1:0] LastOut3 =
    ADDR_W'((IFMD_H - KW_3 + 1) * (IFMD_W - KW_3 + 1) - 1);
  localparam logic [ADDR_W-1:0] LastOut5 =
    ADDR_W'((IFMD_H - KW_5 + 1) * (IFMD_W - KW_5 + 1) - 1);

  typedef enum logic {StIdle, StAccum} state_e;

  state_e                    state_q;
  logic                      k5_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [TapW-1:0]           tap_cnt_q;
  logic [ADDR_W-1:0]         out_cnt_q;

  logic signed [ACC_W-1:0]   sum;
  logic signed [ACC_W-1:0]   wr_val;
  logic                      last_tap;
  logic                      last_out;

  always_comb begin
    sum      = acc_q + {{(ACC_W - PROD_W){prod_data[PROD_W-1]}}, prod_data};
    last_tap = (tap_cnt_q == (k5_q ? LastTap5 : LastTap3));
    last_out = (out_cnt_q == (k5_q ? LastOut5 : LastOut3));
`ifdef OFMD_RELU_EN
    wr_val   = sum[ACC_W-1] ? '0 : sum;
`else
    wr_val   = sum;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      k5_q         <= 1'b0;
      acc_q        <= '0;
      tap_cnt_q    <= '0;
      out_cnt_q    <= '0;
      ofmd_wr_en   <= 1'b0;
      ofmd_wr_addr <= '0;
      ofmd_wr_data <= '0;
      ofmd_wr_done <= 1'b0;
      busy         <= 1'b0;
      align_err    <= 1'b0;
    end else begin
      ofmd_wr_en   <= 1'b0;
      ofmd_wr_done <= 1'b0;
      case (state_q)
        StIdle: begin
          // busy is still high during the final write cycle, so start is refused there too
          if (start && !busy) begin
            state_q   <= StAccum;
            busy      <= 1'b1;
            align_err <= 1'b0;
            acc_q     <= '0;
            tap_cnt_q <= '0;
            out_cnt_q <= '0;
            k5_q      <= is_5x5;
          end else begin
            busy <= 1'b0;
          end
        end
        StAccum: begin
          if (prod_valid) begin
            if (win_last != last_tap) align_err <= 1'b1;
            if (last_tap) begin
              ofmd_wr_en   <= 1'b1;
              ofmd_wr_addr <= out_cnt_q;
              ofmd_wr_data <= wr_val;
              acc_q        <= '0;
              tap_cnt_q    <= '0;
              out_cnt_q    <= out_cnt_q + 1'b1;
              if (last_out) begin
                ofmd_wr_done <= 1'b1;
                state_q      <= StIdle;
              end
            end else begin
              acc_q     <= sum;
              tap_cnt_q <= tap_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmd_wr_addr_gener.sv
// Directed self-checking bench for ofmd_wr_addr_gener; expected sums follow OFMD_RELU_EN.
module tb_ofmd_wr_addr_gener;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               is_5x5;
  logic               prod_valid;
  logic signed [15:0] prod_data;
  logic               win_last;
  logic               ofmd_wr_en;
  logic [5:0]         ofmd_wr_addr;
  logic signed [20:0] ofmd_wr_data;
  logic               ofmd_wr_done;
  logic               busy;
  logic               align_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;

  ofmd_wr_addr_gener dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .is_5x5       (is_5x5),
    .prod_valid   (prod_valid),
    .prod_data    (prod_data),
    .win_last     (win_last),
    .ofmd_wr_en   (ofmd_wr_en),
    .ofmd_wr_addr (ofmd_wr_addr),
    .ofmd_wr_data (ofmd_wr_data),
    .ofmd_wr_done (ofmd_wr_done),
    .busy         (busy),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ofmd_wr_en) n_wr++;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint relu(input longint v);
`ifdef OFMD_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic drive(input logic s, input logic k5, input logic v, input int d, input logic wl);
    @(negedge clk);
    start      = s;
    is_5x5     = k5;
    prod_valid = v;
    prod_data  = 16'(d);
    win_last   = wl;
  endtask

  // bad_tap: extra win_last on this 1-based tap of window 0 (0 = none).
  // spur: start pulses with flipped is_5x5 mid-map and on the final tap.
  task automatic run_map(input logic k5, input int val, input int max_gap, input int bad_tap,
                         input logic spur, input logic exp_err);
    int taps;
    int total;
    int wr0;
    logic s;
    taps  = k5 ? 25 : 9;
    total = k5 ? 16 : 36;
    drive(1'b1, k5, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", align_err, 0);
    wr0 = n_wr;
    for (int w = 0; w < total; w++) begin
      for (int t = 0; t < taps; t++) begin
        if (max_gap > 0) begin
          int g;
          g = $urandom_range(1, max_gap);
          for (int i = 0; i < g; i++) drive(1'b0, k5, 1'b0, 0, 1'b0);
        end
        s = spur && ((w == 1 && t == 2) || (w == total - 1 && t == taps - 1));
        drive(s, s ? ~k5 : k5, 1'b1, val,
              (t == taps - 1) || (w == 0 && t == bad_tap - 1));
      end
      @(posedge clk); #1;
      check("wr_en", ofmd_wr_en, 1);
      check("wr_addr", ofmd_wr_addr, w);
      check("wr_data", ofmd_wr_data, relu(longint'(val) * taps));
      check("wr_done", ofmd_wr_done, (w == total - 1) ? 1 : 0);
      check("busy_at_write", busy, 1);
      check("align_err", align_err, exp_err);
    end
    drive(1'b0, k5, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    check("busy_after_done", busy, 0);
    check("wr_en_pulse", ofmd_wr_en, 0);
    check("done_pulse", ofmd_wr_done, 0);
    check("align_err_end", align_err, exp_err);
    check("write_count", n_wr - wr0, total);
  endtask

  initial begin
    int wr0;
    rst = 1'b1; start = 0; is_5x5 = 0; prod_valid = 0; prod_data = 0; win_last = 0;
    #1;
    check("rst_wr_en", ofmd_wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", ofmd_wr_addr, 0);
    check("rst_data", ofmd_wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 3x3 back-to-back, +1 products
    run_map(1'b0, 1, 0, 0, 1'b0, 1'b0);
    // 5x5 with 1-3 cycle gaps, -2 products
    run_map(1'b1, -2, 3, 0, 1'b0, 1'b0);
    // Misaligned win_last on tap 4 of window 0
    run_map(1'b0, 1, 0, 4, 1'b0, 1'b1);
    // prod_valid in IDLE is ignored
    wr0 = n_wr;
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 1'b1, 7, (i % 9) == 8);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    check("idle_no_writes", n_wr - wr0, 0);
    check("idle_busy", busy, 0);
    check("idle_err_held", align_err, 1);
    // Spurious start while busy; next start clears align_err
    run_map(1'b1, 3, 0, 0, 1'b1, 1'b0);
    run_map(1'b0, -5, 0, 0, 1'b1, 1'b0);
    // Most-negative product on all 25 taps
    run_map(1'b1, -32768, 0, 0, 1'b0, 1'b0);

    // Reset after 100 taps of a 3x3 map
    drive(1'b1, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 100; i++) drive(1'b0, 1'b0, 1'b1, 1, (i % 9) == 8);
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_addr", ofmd_wr_addr, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", ofmd_wr_addr, 0);
    check("mid_rst_data", ofmd_wr_data, 0);
    check("mid_rst_wr_en", ofmd_wr_en, 0);
    wr0 = n_wr;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 1, (i % 9) == 8);
    drive(1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_no_writes", n_wr - wr0, 0);
    check("post_rst_busy", busy, 0);
    run_map(1'b0, 2, 0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
